cska_pipe_addsub: RTL and testbench
===================================

Name: cska_pipe_addsub

Overview:
Parametrised, pipelined carry-skip adder/subtractor: the next generation of the team's 32-bit combinational carry-skip adder. It adds width, block-size and pipeline-depth parameters, a subtract mode, carry/borrow-in, carry-out and signed overflow. A valid/ready handshake lets it sit directly in the datapath between a request FIFO and the result writeback stage. Each pipeline stage resolves one segment of the word with ripple blocks and skip muxes, and registers the carry into the next segment.

Parameters:
WIDTH, 32, operand/result width in bits
BLOCK, 4, ripple block size in bits; one skip mux per block
STAGES, 2, register stages = latency; segment width SEG = WIDTH/STAGES

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  operand beat valid
o_ready  output  1  block can accept a beat this cycle
i_a  input  WIDTH  operand A
i_b  input  WIDTH  operand B
i_sub  input  1  0: A+B+cin; 1: A-B-cin
i_cin  input  1  carry-in (add) / borrow-in (sub)
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_sum  output  WIDTH  result
o_cout  output  1  carry-out of MSB of A + B' + c0 (sub: 1 = no borrow)
o_ovf  output  1  two's-complement signed overflow

Behaviour:
- Legal configurations: STAGES 1..8; WIDTH divisible by BLOCK*STAGES. An illegal configuration stops elaboration ($error in a generate check).
- Arithmetic: B' = i_sub ? ~i_b : i_b; c0 = i_sub ? ~i_cin : i_cin. Result is (A + B' + c0) mod 2^WIDTH. o_cout is bit WIDTH of that sum. o_ovf = (A[MSB] == B'[MSB]) && (o_sum[MSB] != A[MSB]).
- Carry-skip: per block, P = &(a^b'). The block's carry-out is P ? block_cin : ripple_cout. The result must be bit-exact to a ripple adder.
- Pipeline stage k (k = 0..STAGES-1):
  - Computes bits [k*SEG +: SEG] from the registered carry of stage k-1. Stage 0 uses c0.
  - Registers the partial sum, the segment carry-out, a valid bit, and the not-yet-consumed upper operand bits (B' already inverted).
  - The last stage registers o_sum, o_cout, o_ovf and o_valid.
- Latency: a beat accepted at edge N appears on o_valid/o_sum after edge N+STAGES-1 (STAGES register stages, no output comb path).
- Throughput: one beat per cycle while i_ready=1.
- Handshake:
  - Global enable en = ~o_valid | i_ready. o_ready = en.
  - Input accepted when i_valid & o_ready. All stages shift only when en=1.
  - When en=1 with no accepted input, a bubble (valid=0) enters stage 0.
  - Bubbles are not collapsed while stalled.
  - When o_valid=1 and i_ready=0: o_sum, o_cout, o_ovf and o_valid hold stable; no stage changes.
- Data registers load only when en=1. Their contents are don't-care when the matching valid bit is 0.
- Reset (asynchronous assert, synchronous release on i_clk):
  - All valid bits clear to 0, so o_valid=0.
  - o_sum=0, o_cout=0, o_ovf=0.
  - o_ready=1 from the first cycle after release.
  - Reset mid-operation discards every in-flight beat; none emerges after release.
- Boundaries:
  - Full-propagate words (A ^ B' all ones) must skip correctly across both block and stage boundaries.
  - i_valid while o_ready=0 is ignored; the source holds the beat.
  - Simultaneous output drain and input accept in the same cycle is legal.

Test Plan:
- Add wrap, WIDTH=32, STAGES=2: A=0xFFFFFFFF, B=0x00000001, sub=0, cin=0 -> after 2 cycles sum=0x00000000, cout=1, ovf=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1. Then A=0x80000000, B=0x00000001, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Borrow: A=5, B=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Same with cin=1 -> sum=0xFFFFFFFD.
- Streaming: 1000 back-to-back random beats with i_ready=1, swept over (WIDTH, BLOCK, STAGES) = (32,4,1), (32,4,2), (64,8,4) -> one result per cycle, in order, matching the reference model, first output at latency STAGES.
- Backpressure: random i_ready (50%) during streaming -> o_sum, o_cout, o_ovf and o_valid stable while o_valid & ~i_ready; o_ready=0 exactly then; no beat lost or duplicated.
- Reset mid-stream: assert i_rst_n=0 asynchronously with STAGES beats in flight -> o_valid drops immediately, all outputs read 0, o_ready=1 after release, no stale beat emerges.

Source files
------------

// File: rtl/cska_pipe_addsub.sv
// Pipelined carry-skip adder/subtractor with valid/ready handshake.
// Each stage resolves one SEG-bit segment with ripple blocks plus skip muxes and
// registers the segment carry, partial sum and remaining operand bits.
module cska_pipe_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned NBLK = SEG / BLOCK;
  localparam int unsigned MSB  = WIDTH - 1;
  localparam int unsigned LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > 8 || (WIDTH % (BLOCK * STAGES)) != 0) begin : g_bad_cfg
    $error("cska_pipe_addsub: illegal WIDTH/BLOCK/STAGES combination");
  end

  // One segment: ripple inside each block, skip mux selects the block carry-out.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           cin);
    logic [SEG-1:0] s;
    logic           c;
    logic           rc;
    logic           p;
    s = '0;
    c = cin;
    for (int unsigned blk = 0; blk < NBLK; blk++) begin
      rc = c;
      p  = 1'b1;
      for (int unsigned i = 0; i < BLOCK; i++) begin
        s[blk*BLOCK+i] = a[blk*BLOCK+i] ^ b[blk*BLOCK+i] ^ rc;
        rc = (a[blk*BLOCK+i] & b[blk*BLOCK+i]) | (rc & (a[blk*BLOCK+i] ^ b[blk*BLOCK+i]));
        p  = p & (a[blk*BLOCK+i] ^ b[blk*BLOCK+i]);
      end
      c = p ? c : rc;
    end
    return {c, s};
  endfunction

  // Stage registers; b_q already holds the conditionally inverted operand.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];
  logic             ovf_q;

  // Per-stage inputs (stage 0 from ports, stage k from stage k-1) and next state.
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             c_in  [STAGES];
  logic             v_in  [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             c_d   [STAGES];
  logic [SEG:0]     seg_r [STAGES];
  logic             ovf_d;
  logic             en;

  assign o_valid = v_q[LAST];
  assign o_sum   = sum_q[LAST];
  assign o_cout  = c_q[LAST];
  assign o_ovf   = ovf_q;
  // The whole pipe advances together; it only freezes when the output is held.
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  // Segment arithmetic for every stage plus overflow of the final word.
  always_comb begin
    a_in[0] = i_a;
    b_in[0] = i_sub ? ~i_b : i_b;
    c_in[0] = i_sub ^ i_cin;
    s_in[0] = '0;
    v_in[0] = i_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      s_in[k] = sum_q[k-1];
      v_in[k] = v_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_r[k] = seg_add(a_in[k][k*SEG +: SEG], b_in[k][k*SEG +: SEG], c_in[k]);
      sum_d[k] = s_in[k];
      sum_d[k][k*SEG +: SEG] = seg_r[k][SEG-1:0];
      c_d[k]   = seg_r[k][SEG];
    end
    ovf_d = (a_in[LAST][MSB] == b_in[LAST][MSB]) && (sum_d[LAST][MSB] != a_in[LAST][MSB]);
  end

  // Pipeline registers: cleared on reset, shift only while enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
        v_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        sum_q[k] <= sum_d[k];
        c_q[k]   <= c_d[k];
        v_q[k]   <= v_in[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cska_pipe_addsub.sv
// Self-checking bench: three configurations driven side by side, each with its
// own scoreboard queue fed from an independent arithmetic model.
module tb_cska_pipe_addsub;

  logic clk;
  logic rst_n;

  logic        vld [3];
  logic        rdy [3];
  logic        sub [3];
  logic        cin [3];
  logic [63:0] a   [3];
  logic [63:0] b   [3];

  logic        ovalid [3];
  logic        oready [3];
  logic        ocout  [3];
  logic        oovf   [3];
  logic [63:0] osum   [3];

  logic        v0, r0, c0, f0;
  logic        v1, r1, c1, f1;
  logic        v2, r2, c2, f2;
  logic [31:0] s0, s1;
  logic [63:0] s2;

  int unsigned wid [3];
  int unsigned stg [3];

  logic [65:0] sb [3][$];
  logic        pend [3];
  logic        hold [3];
  logic [65:0] snap [3];
  int          gen_left [3];
  int          pops [3];
  int          first_pop [3];
  int          last_pop [3];
  logic [63:0] da [3];
  logic [63:0] db [3];
  logic        dsub [3];
  logic        dcin [3];
  int          stepn;

  int n_tests;
  int n_fail;

  cska_pipe_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .o_ready(r0),
    .i_a(a[0][31:0]), .i_b(b[0][31:0]), .i_sub(sub[0]), .i_cin(cin[0]),
    .o_valid(v0), .i_ready(rdy[0]), .o_sum(s0), .o_cout(c0), .o_ovf(f0)
  );

  cska_pipe_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .o_ready(r1),
    .i_a(a[1][31:0]), .i_b(b[1][31:0]), .i_sub(sub[1]), .i_cin(cin[1]),
    .o_valid(v1), .i_ready(rdy[1]), .o_sum(s1), .o_cout(c1), .o_ovf(f1)
  );

  cska_pipe_addsub #(.WIDTH(64), .BLOCK(8), .STAGES(4)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[2]), .o_ready(r2),
    .i_a(a[2]), .i_b(b[2]), .i_sub(sub[2]), .i_cin(cin[2]),
    .o_valid(v2), .i_ready(rdy[2]), .o_sum(s2), .o_cout(c2), .o_ovf(f2)
  );

  always_comb begin
    ovalid[0] = v0; oready[0] = r0; ocout[0] = c0; oovf[0] = f0; osum[0] = {32'd0, s0};
    ovalid[1] = v1; oready[1] = r1; ocout[1] = c1; oovf[1] = f1; osum[1] = {32'd0, s1};
    ovalid[2] = v2; oready[2] = r2; ocout[2] = c2; oovf[2] = f2; osum[2] = s2;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int unsigned w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: plain wide addition, result packed as {cout, ovf, sum}.
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic s, input logic ci, input int unsigned w);
    logic [63:0] m, xx, yy, sm;
    logic [64:0] full;
    logic        co, ov;
    m    = wmask(w);
    xx   = x & m;
    yy   = (s ? ~y : y) & m;
    full = {1'b0, xx} + {1'b0, yy} + {64'd0, s ^ ci};
    sm   = full[63:0] & m;
    co   = full[w];
    ov   = (xx[w-1] == yy[w-1]) && (sm[w-1] != xx[w-1]);
    return {co, ov, sm};
  endfunction

  // gen_mode: 0 none, 1 random every cycle, 2 random 50%, 3 directed from da/db.
  task automatic step(input int gen_mode, input bit rand_rdy);
    logic [65:0] exp;
    @(negedge clk);
    stepn++;
    for (int g = 0; g < 3; g++) begin
      if (hold[g]) begin
        check($sformatf("g%0d_hold_out", g), {ocout[g], oovf[g], osum[g]}, snap[g]);
        check($sformatf("g%0d_hold_valid", g), 66'(ovalid[g]), 66'(1));
      end
      rdy[g] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!pend[g] && gen_left[g] > 0 &&
          (gen_mode == 1 || gen_mode == 3 || (gen_mode == 2 && $urandom_range(0, 1) == 1))) begin
        if (gen_mode == 3) begin
          a[g] = da[g]; b[g] = db[g]; sub[g] = dsub[g]; cin[g] = dcin[g];
        end else begin
          a[g]   = {$urandom, $urandom};
          b[g]   = {$urandom, $urandom};
          sub[g] = 1'($urandom_range(0, 1));
          cin[g] = 1'($urandom_range(0, 1));
        end
        pend[g] = 1'b1;
        gen_left[g]--;
      end
      vld[g] = pend[g];
    end
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("g%0d_o_ready", g), 66'(oready[g]), 66'(!ovalid[g] || rdy[g]));
      if (ovalid[g] && rdy[g]) begin
        if (sb[g].size() == 0) begin
          check($sformatf("g%0d_spurious_valid", g), 66'(ovalid[g]), 66'(0));
        end else begin
          exp = sb[g].pop_front();
          check($sformatf("g%0d_result", g), {ocout[g], oovf[g], osum[g]}, exp);
          pops[g]++;
          if (first_pop[g] == 0) first_pop[g] = stepn;
          last_pop[g] = stepn;
        end
      end
      if (vld[g] && oready[g]) begin
        sb[g].push_back(model(a[g], b[g], sub[g], cin[g], wid[g]));
        pend[g] = 1'b0;
      end
      hold[g] = ovalid[g] && !rdy[g];
      snap[g] = {ocout[g], oovf[g], osum[g]};
    end
  endtask

  task automatic clear_book();
    stepn = 0;
    for (int g = 0; g < 3; g++) begin
      pops[g] = 0; first_pop[g] = 0; last_pop[g] = 0;
    end
  endtask

  initial begin
    logic [63:0] m;
    n_tests = 0;
    n_fail  = 0;
    wid[0] = 32; wid[1] = 32; wid[2] = 64;
    stg[0] = 1;  stg[1] = 2;  stg[2] = 4;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      vld[g] = 1'b0; rdy[g] = 1'b1; sub[g] = 1'b0; cin[g] = 1'b0;
      a[g] = '0; b[g] = '0; pend[g] = 1'b0; hold[g] = 1'b0; snap[g] = '0; gen_left[g] = 0;
    end
    clear_book();

    #12;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("g%0d_rst_valid", g), 66'(ovalid[g]), 66'(0));
      check($sformatf("g%0d_rst_out", g), {ocout[g], oovf[g], osum[g]}, 66'(0));
      check($sformatf("g%0d_rst_ready", g), 66'(oready[g]), 66'(1));
    end
    #10 rst_n = 1'b1;

    // Directed corner vectors, width-generic, each drained before the next.
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < 3; g++) begin
        m = wmask(wid[g]);
        dsub[g] = 1'b0; dcin[g] = 1'b0;
        unique case (i)
          0: begin da[g] = m; db[g] = 64'd1; end
          1: begin da[g] = m >> 1; db[g] = 64'd1; end
          2: begin da[g] = (m >> 1) + 64'd1; db[g] = 64'd1; dsub[g] = 1'b1; end
          3: begin da[g] = 64'd5; db[g] = 64'd7; dsub[g] = 1'b1; end
          4: begin da[g] = 64'd5; db[g] = 64'd7; dsub[g] = 1'b1; dcin[g] = 1'b1; end
          5: begin da[g] = 64'hAAAA_AAAA_AAAA_AAAA & m; db[g] = 64'h5555_5555_5555_5555 & m;
                   dcin[g] = 1'b1; end
          6: begin da[g] = 64'hAAAA_AAAA_AAAA_AAAA & m; db[g] = 64'h5555_5555_5555_5555 & m; end
          default: begin da[g] = 64'h1234_5678_9ABC_DEF0 & m; db[g] = da[g]; dsub[g] = 1'b1;
                         dcin[g] = 1'b0; end
        endcase
        gen_left[g] = 1;
      end
      step(3, 1'b0);
      for (int j = 0; j < 6; j++) step(0, 1'b0);
    end

    // Back-to-back streaming: one result per cycle, first after STAGES edges.
    clear_book();
    for (int g = 0; g < 3; g++) gen_left[g] = 1000;
    for (int j = 0; j < 1006; j++) step(1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("g%0d_stream_pops", g), 66'(pops[g]), 66'(1000));
      check($sformatf("g%0d_stream_first", g), 66'(first_pop[g]), 66'(1 + stg[g]));
      check($sformatf("g%0d_stream_last", g), 66'(last_pop[g]), 66'(1000 + stg[g]));
    end

    // Random backpressure and random source gaps.
    clear_book();
    for (int g = 0; g < 3; g++) gen_left[g] = 200;
    for (int j = 0; j < 3000; j++) begin
      if (gen_left[0] == 0 && gen_left[1] == 0 && gen_left[2] == 0 &&
          !pend[0] && !pend[1] && !pend[2]) break;
      step(2, 1'b1);
    end
    for (int j = 0; j < 20; j++) step(0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("g%0d_bp_pops", g), 66'(pops[g]), 66'(200));
      check($sformatf("g%0d_bp_left", g), 66'(sb[g].size()), 66'(0));
    end

    // Asynchronous reset with beats in flight.
    for (int g = 0; g < 3; g++) gen_left[g] = 100;
    for (int j = 0; j < 5; j++) step(1, 1'b0);
    @(posedge clk);
    #2;
    for (int g = 0; g < 3; g++) check($sformatf("g%0d_pre_rst_valid", g), 66'(ovalid[g]), 66'(1));
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("g%0d_midrst_valid", g), 66'(ovalid[g]), 66'(0));
      check($sformatf("g%0d_midrst_out", g), {ocout[g], oovf[g], osum[g]}, 66'(0));
      sb[g].delete();
      pend[g] = 1'b0; hold[g] = 1'b0; vld[g] = 1'b0; gen_left[g] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int g = 0; g < 3; g++) check($sformatf("g%0d_rel_ready", g), 66'(oready[g]), 66'(1));
    clear_book();
    for (int j = 0; j < 12; j++) step(0, 1'b0);
    for (int g = 0; g < 3; g++) check($sformatf("g%0d_stale_pops", g), 66'(pops[g]), 66'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
